// File: rtl/line_buf_pkg.sv
// Shared defaults and width helper for the line-delay tap chain.
package line_buf_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LINE_LEN = 800;
  localparam int DEF_NUM_TAPS = 24;

  // Bits needed to index 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// One line of pixel storage: DEPTH x WIDTH array with registered, read-before-write output.
module line_buf_ram
  import line_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_LINE_LEN,
  parameter int AW    = clog2(DEF_LINE_LEN)
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register doubles as the tap; cleared by reset, contents are not.
  always_ff @(posedge clock) begin
    if (sclr)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_buf_taps.sv
// Line-delay tap chain: tap k is the pixel (k+1) lines back at the same column.
module line_buf_taps
  import line_buf_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LINE_LEN = DEF_LINE_LEN,
  parameter int NUM_TAPS = DEF_NUM_TAPS
) (
  input  logic                        clock,
  input  logic                        sclr,
  input  logic                        clken,
  input  logic                        sof,
  input  logic [WIDTH-1:0]            shiftin,
  output logic [NUM_TAPS*WIDTH-1:0]   taps,
  output logic [WIDTH-1:0]            shiftout,
  output logic [NUM_TAPS-1:0]         tap_valid,
  output logic [clog2(LINE_LEN)-1:0]  col,
  output logic                        line_end
);

  localparam int CW = clog2(LINE_LEN);
  localparam int LW = clog2(NUM_TAPS + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_LEN - 1);

  logic              en;
  logic [CW-1:0]     addr;
  logic              at_last;
  logic [CW-1:0]     col_reg, col_next;
  logic [LW-1:0]     lines_reg, lines_next;
  logic [NUM_TAPS-1:0] valid_reg, valid_next;
  logic              line_end_reg;
  logic              pend_reg;
  logic              wr_en;
  logic [CW-1:0]     wr_addr_reg;
  logic [WIDTH-1:0]  shiftin_reg;
  logic [WIDTH-1:0]  chain [NUM_TAPS+1];

  assign en      = clken & ~sclr;
  assign addr    = sof ? '0 : col_reg;
  assign at_last = (addr == LAST_COL);

  always_comb begin
    col_next   = col_reg;
    lines_next = lines_reg;
    if (sof) begin
      col_next   = CW'(1);
      lines_next = '0;
    end else begin
      col_next = at_last ? '0 : addr + CW'(1);
      if (at_last && (lines_reg != LW'(NUM_TAPS))) lines_next = lines_reg + LW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_valid
      assign valid_next[gi] = (lines_next >= LW'(gi + 1));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (sclr) begin
      col_reg      <= '0;
      lines_reg    <= '0;
      valid_reg    <= '0;
      line_end_reg <= 1'b0;
      pend_reg     <= 1'b0;
    end else if (clken) begin
      col_reg      <= col_next;
      lines_reg    <= lines_next;
      valid_reg    <= valid_next;
      line_end_reg <= at_last;
      pend_reg     <= 1'b1;
    end else begin
      line_end_reg <= 1'b0;
    end
  end

  // Each stage stores its input one enabled cycle late at the column that input
  // belongs to; that absorbs the tap register so every stage delays exactly one line.
  always_ff @(posedge clock) begin
    if (en) begin
      wr_addr_reg <= addr;
      shiftin_reg <= shiftin;
    end
  end

  // The pending write is flushed on a reset edge too, so no pixel is lost.
  assign wr_en    = pend_reg & (clken | sclr);
  assign chain[0] = shiftin_reg;

  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_stage
      line_buf_ram #(
        .WIDTH (WIDTH),
        .DEPTH (LINE_LEN),
        .AW    (CW)
      ) u_ram (
        .clock   (clock),
        .sclr    (sclr),
        .rd_en   (en),
        .rd_addr (addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_reg),
        .wr_data (chain[gi]),
        .rd_data (chain[gi+1])
      );
      assign taps[gi*WIDTH +: WIDTH] = chain[gi+1];
    end
  endgenerate

  assign shiftout  = chain[NUM_TAPS];
  assign tap_valid = valid_reg;
  assign col       = col_reg;
  assign line_end  = line_end_reg;

endmodule
